// File: rtl/dvp_pattern_source_pkg.sv
// Shared definitions for the DVP test-pattern source: FSM states, pattern codes,
// colour-bar table and frame-geometry helpers.
package dvp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFRONT = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_GRAD  = 2'd1,
    PAT_SOLID = 2'd2,
    PAT_CHECK = 2'd3
  } pattern_t;

  // Entry 0 is the leftmost bar.
  localparam logic [7:0][15:0] BAR_RGB = {
    16'h0000, 16'h001F, 16'hF800, 16'hF81F,
    16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
  };

  function automatic int h_total_bytes(input int h_active, input int h_blank);
    return 2 * (h_active + h_blank);
  endfunction

  function automatic int v_total_lines(input int v_sync, input int v_back,
                                       input int v_active, input int v_front);
    return v_sync + v_back + v_active + v_front;
  endfunction

  function automatic int first_active_line(input int v_sync, input int v_back);
    return v_sync + v_back;
  endfunction

endpackage

// File: rtl/dvp_pattern_source_if.sv
// DVP camera-side output bundle: sync strobes, byte data and frame status.
interface dvp_if;
  logic       v_sync;
  logic       h_ref;
  logic [7:0] data_out;
  logic       frame_start;
  logic       busy;

  modport master (output v_sync, h_ref, data_out, frame_start, busy);
  modport slave  (input  v_sync, h_ref, data_out, frame_start, busy);
endinterface

// File: rtl/dvp_pattern_source_gen.sv
// Combinational RGB565 test-pattern generator: pixel (x, y) -> 16-bit colour.
module dvp_pattern_gen
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE = 640
) (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  pattern_t    pattern_sel,
  input  logic [15:0] solid_rgb,
  output logic [15:0] pix
);

  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  logic [15:0] bar_idx;
  logic        unused_y;

  assign unused_y = ^{y[15:5], y[3:0]};

  always_comb begin
    bar_idx = x / 16'(BAR_W);
    pix     = 16'h0000;
    case (pattern_sel)
      // Rounding leftovers when H_ACTIVE is not a multiple of 8 fall into the last bar.
      PAT_BARS:  pix = BAR_RGB[(bar_idx > 16'd7) ? 3'd7 : bar_idx[2:0]];
      PAT_GRAD:  pix = {x[9:5], x[9:4], x[9:5]};
      PAT_SOLID: pix = solid_rgb;
      PAT_CHECK: pix = (x[4] ^ y[4]) ? 16'hFFFF : 16'h0000;
      default:   pix = 16'h0000;
    endcase
  end

endmodule

// File: rtl/dvp_pattern_source.sv
// OV7670-style DVP transmitter driven from an internal test pattern, one byte per clk_25.
// Outputs are registered from next-state values so they line up with the FSM/counters.
module dvp_pattern_source
  import dvp_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 144,
  parameter int V_SYNC   = 3,
  parameter int V_BACK   = 17,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10
) (
  input  logic        clk_25,
  input  logic        reset,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_rgb,
  dvp_if.master       dvp
);

  localparam int H_TOTAL_BYTES = h_total_bytes(H_ACTIVE, H_BLANK);
  localparam int V_TOTAL_LINES = v_total_lines(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);
  localparam int FIRST_ACTIVE  = first_active_line(V_SYNC, V_BACK);
  localparam int END_SYNC      = V_SYNC;
  localparam int END_BACK      = V_SYNC + V_BACK;
  localparam int END_ACTIVE    = V_SYNC + V_BACK + V_ACTIVE;
  localparam int BW            = $clog2(H_TOTAL_BYTES);
  localparam int LW            = (V_TOTAL_LINES > 1) ? $clog2(V_TOTAL_LINES) : 1;
  localparam logic [BW-1:0] BYTE_LAST = BW'(H_TOTAL_BYTES - 1);
  localparam logic [LW-1:0] LINE_LAST = LW'(V_TOTAL_LINES - 1);

  state_t      state, state_nxt;
  logic [BW-1:0] byte_cnt, byte_nxt;
  logic [LW-1:0] line_cnt, line_nxt;
  pattern_t    sel_q, sel_nxt;
  logic [15:0] solid_q, solid_nxt;
  logic        new_frame;

  logic        vs_d, href_d, fs_d, busy_d;
  logic [7:0]  dat_d;
  logic [15:0] pix_x, pix_y, pix;

  // Zero-line regions are skipped naturally: the state is a pure function of the line.
  function automatic state_t line_state(input logic [LW-1:0] l);
    state_t s;
    if (int'(l) < END_SYNC)        s = ST_VSYNC;
    else if (int'(l) < END_BACK)   s = ST_VBACK;
    else if (int'(l) < END_ACTIVE) s = ST_ACTIVE;
    else                           s = ST_VFRONT;
    return s;
  endfunction

  always_ff @(posedge clk_25) begin
    if (reset) begin
      state    <= ST_IDLE;
      byte_cnt <= '0;
      line_cnt <= '0;
      sel_q    <= PAT_BARS;
      solid_q  <= 16'h0000;
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_nxt;
      line_cnt <= line_nxt;
      sel_q    <= sel_nxt;
      solid_q  <= solid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    byte_nxt  = byte_cnt;
    line_nxt  = line_cnt;
    new_frame = 1'b0;
    if (state == ST_IDLE) begin
      if (enable) begin
        new_frame = 1'b1;
        state_nxt = line_state('0);
      end
    end else if (byte_cnt == BYTE_LAST) begin
      byte_nxt = '0;
      if (line_cnt == LINE_LAST) begin
        line_nxt = '0;
        if (enable) begin
          new_frame = 1'b1;
          state_nxt = line_state('0);
        end else begin
          state_nxt = ST_IDLE;
        end
      end else begin
        line_nxt  = line_cnt + LW'(1);
        state_nxt = line_state(line_cnt + LW'(1));
      end
    end else begin
      byte_nxt = byte_cnt + BW'(1);
    end
  end

  // Pattern controls are frozen for the whole frame.
  always_comb begin
    sel_nxt   = sel_q;
    solid_nxt = solid_q;
    if (new_frame) begin
      sel_nxt   = pattern_t'(pattern_sel);
      solid_nxt = solid_rgb;
    end
  end

  assign pix_x = 16'(byte_nxt) >> 1;
  assign pix_y = 16'(line_nxt) - 16'(FIRST_ACTIVE);

  dvp_pattern_gen #(
    .H_ACTIVE (H_ACTIVE)
  ) u_gen (
    .x           (pix_x),
    .y           (pix_y),
    .pattern_sel (sel_nxt),
    .solid_rgb   (solid_nxt),
    .pix         (pix)
  );

  always_comb begin
    vs_d   = (state_nxt == ST_VSYNC);
    href_d = (state_nxt == ST_ACTIVE) && (int'(byte_nxt) < 2 * H_ACTIVE);
    dat_d  = 8'h00;
    if (href_d) dat_d = byte_nxt[0] ? pix[7:0] : pix[15:8];
    fs_d   = new_frame && (state_nxt == ST_VSYNC);
    busy_d = (state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk_25) begin
    if (reset) begin
      dvp.v_sync      <= 1'b0;
      dvp.h_ref       <= 1'b0;
      dvp.data_out    <= 8'h00;
      dvp.frame_start <= 1'b0;
      dvp.busy        <= 1'b0;
    end else begin
      dvp.v_sync      <= vs_d;
      dvp.h_ref       <= href_d;
      dvp.data_out    <= dat_d;
      dvp.frame_start <= fs_d;
      dvp.busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_dvp_pattern_source.sv
// Directed bench: small-geometry DUT checked against hand-computed vectors, plus a
// wider DUT exercising gradient/checker patterns against a reference formula.
module tb_dvp_pattern_source;

  logic        clk_25 = 1'b0;
  logic        reset, enable;
  logic [1:0]  pattern_sel;
  logic [15:0] solid_rgb;
  logic        reset2, enable2;
  logic [1:0]  sel2;

  dvp_if dvp1();
  dvp_if dvp2();

  always #5 clk_25 = ~clk_25;

  dvp_pattern_source #(
    .H_ACTIVE(8), .H_BLANK(2), .V_SYNC(1), .V_BACK(1), .V_ACTIVE(2), .V_FRONT(1)
  ) dut (
    .clk_25(clk_25), .reset(reset), .enable(enable),
    .pattern_sel(pattern_sel), .solid_rgb(solid_rgb), .dvp(dvp1)
  );

  dvp_pattern_source #(
    .H_ACTIVE(64), .H_BLANK(2), .V_SYNC(1), .V_BACK(1), .V_ACTIVE(32), .V_FRONT(1)
  ) dut2 (
    .clk_25(clk_25), .reset(reset2), .enable(enable2),
    .pattern_sel(sel2), .solid_rgb(16'h1234), .dvp(dvp2)
  );

  typedef struct {
    int         idx;
    logic       vs;
    logic       hr;
    logic [7:0] dat;
    logic       fs;
    logic       bz;
  } vec_t;

  localparam int HT2 = 132;
  localparam int FR2 = 132 * 35;
  localparam int NCAP = 210;

  int checks = 0;
  int errors = 0;

  vec_t       vecs[$];
  logic [7:0] bars[16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                           8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
  logic       cvs[NCAP], chr[NCAP], cfs[NCAP], cbz[NCAP];
  logic [7:0] cd[NCAP];
  int         n_vs, n_hr, n_fs, n_bz;
  int         f, j, ln, b, fs2, bad0, bad1, bad_tail;
  logic       e_hr;
  logic [7:0] e_d;
  logic [15:0] e_pix;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input int idx, input logic vs, input logic hr,
                               input logic [7:0] dat, input logic fs, input logic bz);
    vec_t v;
    v.idx = idx; v.vs = vs; v.hr = hr; v.dat = dat; v.fs = fs; v.bz = bz;
    return v;
  endfunction

  function automatic logic [15:0] grad_pix(input int xi);
    logic [15:0] x;
    x = 16'(xi);
    return {x[9:5], x[9:4], x[9:5]};
  endfunction

  function automatic logic [15:0] chk_pix(input int xi, input int yi);
    logic [15:0] x, y;
    x = 16'(xi);
    y = 16'(yi);
    return (x[4] ^ y[4]) ? 16'hFFFF : 16'h0000;
  endfunction

  initial begin
    // Frame 1: solid ABCD; frame 2: colour bars; enable dropped in frame 2.
    vecs.push_back(mkv(0,   1, 0, 8'h00, 1, 1));
    vecs.push_back(mkv(1,   1, 0, 8'h00, 0, 1));
    vecs.push_back(mkv(19,  1, 0, 8'h00, 0, 1));
    vecs.push_back(mkv(20,  0, 0, 8'h00, 0, 1));
    vecs.push_back(mkv(39,  0, 0, 8'h00, 0, 1));
    vecs.push_back(mkv(40,  0, 1, 8'hAB, 0, 1));
    vecs.push_back(mkv(41,  0, 1, 8'hCD, 0, 1));
    vecs.push_back(mkv(55,  0, 1, 8'hCD, 0, 1));
    vecs.push_back(mkv(56,  0, 0, 8'h00, 0, 1));
    vecs.push_back(mkv(59,  0, 0, 8'h00, 0, 1));
    vecs.push_back(mkv(60,  0, 1, 8'hAB, 0, 1));
    vecs.push_back(mkv(75,  0, 1, 8'hCD, 0, 1));
    vecs.push_back(mkv(76,  0, 0, 8'h00, 0, 1));
    vecs.push_back(mkv(80,  0, 0, 8'h00, 0, 1));
    vecs.push_back(mkv(99,  0, 0, 8'h00, 0, 1));
    vecs.push_back(mkv(100, 1, 0, 8'h00, 1, 1));
    vecs.push_back(mkv(101, 1, 0, 8'h00, 0, 1));
    vecs.push_back(mkv(120, 0, 0, 8'h00, 0, 1));
    for (int k = 0; k < 16; k++) begin
      vecs.push_back(mkv(140 + k, 0, 1, bars[k], 0, 1));
      vecs.push_back(mkv(160 + k, 0, 1, bars[k], 0, 1));
    end
    vecs.push_back(mkv(156, 0, 0, 8'h00, 0, 1));
    vecs.push_back(mkv(199, 0, 0, 8'h00, 0, 1));
    vecs.push_back(mkv(200, 0, 0, 8'h00, 0, 0));
    vecs.push_back(mkv(209, 0, 0, 8'h00, 0, 0));

    reset = 1'b1; enable = 1'b1; pattern_sel = 2'd2; solid_rgb = 16'hABCD;
    reset2 = 1'b1; enable2 = 1'b0; sel2 = 2'd1;

    repeat (3) @(negedge clk_25);
    check("rst_v_sync", 32'(dvp1.v_sync), 32'd0);
    check("rst_h_ref", 32'(dvp1.h_ref), 32'd0);
    check("rst_data", 32'(dvp1.data_out), 32'd0);
    check("rst_frame_start", 32'(dvp1.frame_start), 32'd0);
    check("rst_busy", 32'(dvp1.busy), 32'd0);

    // Two frames, pattern changed mid-frame 1, enable dropped in frame 2 line 2.
    reset = 1'b0;
    reset2 = 1'b0;
    for (int i = 0; i < NCAP; i++) begin
      @(negedge clk_25);
      cvs[i] = dvp1.v_sync; chr[i] = dvp1.h_ref; cd[i] = dvp1.data_out;
      cfs[i] = dvp1.frame_start; cbz[i] = dvp1.busy;
      if (i == 50) pattern_sel = 2'd0;
      if (i == 145) enable = 1'b0;
    end

    foreach (vecs[k]) begin
      check($sformatf("vec%0d", vecs[k].idx),
            {20'd0, cvs[vecs[k].idx], chr[vecs[k].idx], cfs[vecs[k].idx], cbz[vecs[k].idx], cd[vecs[k].idx]},
            {20'd0, vecs[k].vs, vecs[k].hr, vecs[k].fs, vecs[k].bz, vecs[k].dat});
    end

    n_vs = 0; n_hr = 0; n_fs = 0; n_bz = 0;
    for (int i = 0; i < NCAP; i++) begin
      if (i < 100 && cvs[i] === 1'b1) n_vs++;
      if (i < 100 && chr[i] === 1'b1) n_hr++;
      if (cfs[i] === 1'b1) n_fs++;
      if (cbz[i] === 1'b1) n_bz++;
    end
    check("vsync_cycles", 32'(n_vs), 32'd20);
    check("href_cycles", 32'(n_hr), 32'd32);
    check("frame_start_pulses", 32'(n_fs), 32'd2);
    check("busy_cycles", 32'(n_bz), 32'd200);

    // Reset asserted mid-ACTIVE line at byte 5.
    enable = 1'b1; pattern_sel = 2'd2;
    for (int i = 0; i <= 45; i++) @(negedge clk_25);
    check("pre_reset_h_ref", 32'(dvp1.h_ref), 32'd1);
    check("pre_reset_data", 32'(dvp1.data_out), 32'hCD);
    reset = 1'b1;
    @(negedge clk_25);
    check("abort_h_ref", 32'(dvp1.h_ref), 32'd0);
    check("abort_data", 32'(dvp1.data_out), 32'd0);
    check("abort_v_sync", 32'(dvp1.v_sync), 32'd0);
    check("abort_busy", 32'(dvp1.busy), 32'd0);
    check("abort_frame_start", 32'(dvp1.frame_start), 32'd0);
    @(negedge clk_25);
    check("rst_prio_busy", 32'(dvp1.busy), 32'd0);
    check("rst_prio_v_sync", 32'(dvp1.v_sync), 32'd0);
    reset = 1'b0; enable = 1'b0;
    repeat (3) @(negedge clk_25);
    check("idle_busy", 32'(dvp1.busy), 32'd0);
    check("idle_v_sync", 32'(dvp1.v_sync), 32'd0);

    // Wide DUT: gradient frame, sel switched to checker mid-frame, then stop.
    sel2 = 2'd1; enable2 = 1'b1;
    fs2 = 0; bad0 = 0; bad1 = 0; bad_tail = 0;
    for (int i = 0; i < 2 * FR2 + 10; i++) begin
      @(negedge clk_25);
      f = i / FR2; j = i % FR2; ln = j / HT2; b = j % HT2;
      if (f < 2) begin
        e_hr  = (ln >= 2 && ln < 34 && b < 128);
        e_pix = (f == 0) ? grad_pix(b / 2) : chk_pix(b / 2, ln - 2);
        e_d   = e_hr ? ((b % 2 == 1) ? e_pix[7:0] : e_pix[15:8]) : 8'h00;
        if (dvp2.h_ref !== e_hr || dvp2.data_out !== e_d ||
            dvp2.v_sync !== (ln == 0) || dvp2.busy !== 1'b1) begin
          if (f == 0) bad0++;
          else bad1++;
        end
      end else if (dvp2.busy !== 1'b0 || dvp2.h_ref !== 1'b0 || dvp2.v_sync !== 1'b0) begin
        bad_tail++;
      end
      if (dvp2.frame_start === 1'b1) fs2++;
      if (i == 10) sel2 = 2'd3;
      if (i == FR2 + 100) enable2 = 1'b0;
    end
    check("gradient_frame_bad_cycles", 32'(bad0), 32'd0);
    check("checker_frame_bad_cycles", 32'(bad1), 32'd0);
    check("wide_idle_bad_cycles", 32'(bad_tail), 32'd0);
    check("wide_frame_start_pulses", 32'(fs2), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
